test_supervisor: RTL and testbench



---
 rtl/test_supervisor.sv | 126 ++++++++++++
 tb/tb_test_supervisor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/test_supervisor.sv
// Test supervisor for f8 systems: reset sequencing, trap watch and run timeout
// with a sticky done/fail verdict. Define TEST_SUPERVISOR_PASS_EN to add the early-pass input.
module test_supervisor #(
  parameter int RESET_CYCLES   = 5,
  parameter int TIMEOUT_CYCLES = 2045,
  parameter int TRAP_HOLD      = 5,
  parameter int NUM_TRAPS      = 1,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 power_on_reset_n,
  input  logic [NUM_TRAPS-1:0] trap,
`ifdef TEST_SUPERVISOR_PASS_EN
  input  logic                 pass,
`endif
  output logic                 sys_reset,
  output logic                 done,
  output logic                 fail,
  output logic [NUM_TRAPS-1:0] trap_src,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_e;

  // One counter serves both the reset stretch and the post-trap hold window.
  localparam int GUARD_MAX = (RESET_CYCLES > TRAP_HOLD) ? RESET_CYCLES : TRAP_HOLD;
  localparam int GW        = $clog2(GUARD_MAX) + 1;

  localparam logic [GW-1:0]    RST_LAST  = GW'(RESET_CYCLES - 1);
  localparam logic [GW-1:0]    HOLD_LAST = GW'(TRAP_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic                   sys_reset_q;
  logic                   done_q;
  logic                   fail_q;
  logic [NUM_TRAPS-1:0]   trap_src_q;
  logic [CNT_W-1:0]       cycle_count_q;
  logic [GW-1:0]          guard_q;

  logic                   trap_any;
  logic                   early_pass;
  logic                   timeout_hit;
  logic [CNT_W-1:0]       cycle_count_d;

  assign trap_any    = |trap;
  assign timeout_hit = (cycle_count_q == TO_LAST);
  assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);

`ifdef TEST_SUPERVISOR_PASS_EN
  assign early_pass = pass;
`else
  assign early_pass = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state_q       <= S_RESET;
      sys_reset_q   <= 1'b1;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      trap_src_q    <= '0;
      cycle_count_q <= '0;
      guard_q       <= '0;
    end else begin
      case (state_q)
        S_RESET: begin
          guard_q <= guard_q + GW'(1);
          if (guard_q == RST_LAST) begin
            state_q     <= S_RUN;
            sys_reset_q <= 1'b0;
          end
        end

        S_RUN: begin
          cycle_count_q <= cycle_count_d;
          // Trap beats early pass, which beats the timeout.
          if (trap_any) begin
            trap_src_q <= trap;
            guard_q    <= '0;
            state_q    <= S_HOLD;
          end else if (early_pass || timeout_hit) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            fail_q      <= 1'b0;
            sys_reset_q <= 1'b1;
          end
        end

        S_HOLD: begin
          cycle_count_q <= cycle_count_d;
          trap_src_q    <= trap_src_q | trap;
          guard_q       <= guard_q + GW'(1);
          if (guard_q == HOLD_LAST) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            sys_reset_q <= 1'b1;
          end
        end

        S_DONE: begin
          sys_reset_q <= 1'b1;
        end

        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

  assign sys_reset   = sys_reset_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign trap_src    = trap_src_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_test_supervisor.sv
// Directed bench for test_supervisor: one single-core and one four-core instance
// sharing clock and reset; tcount is posedges since the last reset release.
module tb_test_supervisor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap1 = 1'b0;
  logic [3:0]  trap4 = 4'b0;
  logic        sr1, dn1, fl1, ts1;
  logic        sr4, dn4, fl4;
  logic [3:0]  ts4;
  logic [15:0] cc1, cc4;
`ifdef TEST_SUPERVISOR_PASS_EN
  logic        pass1 = 1'b0;
  logic        pass4 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int tcount = 0;

  always #5 clk = ~clk;

  test_supervisor #(.NUM_TRAPS(1)) dut1 (
    .clk              (clk),
    .power_on_reset_n (rst_n),
    .trap             (trap1),
`ifdef TEST_SUPERVISOR_PASS_EN
    .pass             (pass1),
`endif
    .sys_reset        (sr1),
    .done             (dn1),
    .fail             (fl1),
    .trap_src         (ts1),
    .cycle_count      (cc1)
  );

  test_supervisor #(.NUM_TRAPS(4)) dut4 (
    .clk              (clk),
    .power_on_reset_n (rst_n),
    .trap             (trap4),
`ifdef TEST_SUPERVISOR_PASS_EN
    .pass             (pass4),
`endif
    .sys_reset        (sr4),
    .done             (dn4),
    .fail             (fl4),
    .trap_src         (ts4),
    .cycle_count      (cc4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick_to(input int n);
    while (tcount < n) begin
      @(negedge clk);
      tcount++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sr1"}, 32'(sr1), 32'd1);
    check({tag, " dn1"}, 32'(dn1), 32'd0);
    check({tag, " fl1"}, 32'(fl1), 32'd0);
    check({tag, " ts1"}, 32'(ts1), 32'd0);
    check({tag, " cc1"}, 32'(cc1), 32'd0);
    check({tag, " sr4"}, 32'(sr4), 32'd1);
    check({tag, " dn4"}, 32'(dn4), 32'd0);
    check({tag, " ts4"}, 32'(ts4), 32'd0);
    check({tag, " cc4"}, 32'(cc4), 32'd0);
  endtask

  // Assert reset between edges, check the async reset state, release on a negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    @(negedge clk);
    rst_n  = 1'b1;
    tcount = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Reset and plain timeout.
    do_reset("por");
    tick_to(4);
    check("rst sr1 high at 4", 32'(sr1), 32'd1);
    tick_to(5);
    check("rst sr1 low at 5", 32'(sr1), 32'd0);
    check("run cc1 start", 32'(cc1), 32'd0);
    tick_to(2049);
    check("to dn1 early", 32'(dn1), 32'd0);
    check("to cc1 before", 32'(cc1), 32'd2044);
    tick_to(2050);
    check("to dn1", 32'(dn1), 32'd1);
    check("to fl1", 32'(fl1), 32'd0);
    check("to cc1", 32'(cc1), 32'd2045);
    check("to sr1", 32'(sr1), 32'd1);
    check("to dn4", 32'(dn4), 32'd1);
    check("to fl4", 32'(fl4), 32'd0);
    tick_to(2051);
    trap1 = 1'b1;
    trap4 = 4'hF;
    tick_to(2055);
    trap1 = 1'b0;
    trap4 = 4'h0;
    tick_to(2060);
    check("done frozen cc1", 32'(cc1), 32'd2045);
    check("done frozen ts1", 32'(ts1), 32'd0);
    check("done frozen fl1", 32'(fl1), 32'd0);
    check("done frozen ts4", 32'(ts4), 32'd0);
    check("done frozen sr4", 32'(sr4), 32'd1);

    // Traps during RESET are ignored; single and multi-core trap runs.
    do_reset("por2");
    trap1 = 1'b1;
    trap4 = 4'hF;
    tick_to(5);
    trap1 = 1'b0;
    trap4 = 4'h0;
    check("rst-trap ts1", 32'(ts1), 32'd0);
    check("rst-trap ts4", 32'(ts4), 32'd0);
    check("rst-trap sr4", 32'(sr4), 32'd0);
    check("rst-trap dn4", 32'(dn4), 32'd0);
    tick_to(15);
    trap4 = 4'b0010;
    tick_to(16);
    trap4 = 4'b0000;
    check("mc ts4 first", 32'(ts4), 32'h2);
    check("mc cc4", 32'(cc4), 32'd11);
    check("mc sr4 hold", 32'(sr4), 32'd0);
    tick_to(18);
    trap4 = 4'b1000;
    tick_to(19);
    trap4 = 4'b0000;
    tick_to(20);
    check("mc dn4 early", 32'(dn4), 32'd0);
    tick_to(21);
    check("mc dn4", 32'(dn4), 32'd1);
    check("mc fl4", 32'(fl4), 32'd1);
    check("mc ts4", 32'(ts4), 32'hA);
    check("mc cc4 frozen", 32'(cc4), 32'd16);
    tick_to(105);
    trap1 = 1'b1;
    tick_to(106);
    trap1 = 1'b0;
    check("st cc1", 32'(cc1), 32'd101);
    check("st dn1 hold", 32'(dn1), 32'd0);
    check("st ts1 hold", 32'(ts1), 32'd1);
    tick_to(110);
    check("st dn1 early", 32'(dn1), 32'd0);
    tick_to(111);
    check("st dn1", 32'(dn1), 32'd1);
    check("st fl1", 32'(fl1), 32'd1);
    check("st ts1", 32'(ts1), 32'd1);
    check("st cc1 frozen", 32'(cc1), 32'd106);
    check("st sr1", 32'(sr1), 32'd1);
    tick_to(120);
    check("st cc1 later", 32'(cc1), 32'd106);

    // Trap on the timeout cycle wins.
    do_reset("por3");
    tick_to(2049);
    trap1 = 1'b1;
    trap4 = 4'b0100;
    tick_to(2050);
    trap1 = 1'b0;
    trap4 = 4'b0000;
    check("sim dn1 not pass", 32'(dn1), 32'd0);
    check("sim sr1 hold", 32'(sr1), 32'd0);
    tick_to(2055);
    check("sim dn1", 32'(dn1), 32'd1);
    check("sim fl1", 32'(fl1), 32'd1);
    check("sim fl4", 32'(fl4), 32'd1);
    check("sim ts4", 32'(ts4), 32'h4);

    // Asynchronous reset while in HOLD, then a fresh normal run.
    do_reset("por4");
    tick_to(25);
    trap1 = 1'b1;
    tick_to(26);
    trap1 = 1'b0;
    tick_to(28);
    check("mid ts1 before", 32'(ts1), 32'd1);
    do_reset("mid");
    tick_to(4);
    check("mid sr1 high at 4", 32'(sr1), 32'd1);
    tick_to(5);
    check("mid sr1 low at 5", 32'(sr1), 32'd0);
    tick_to(2049);
    check("mid dn1 early", 32'(dn1), 32'd0);
    tick_to(2050);
    check("mid dn1", 32'(dn1), 32'd1);
    check("mid fl1", 32'(fl1), 32'd0);
    check("mid cc1", 32'(cc1), 32'd2045);

`ifdef TEST_SUPERVISOR_PASS_EN
    // Early pass, and trap taking priority over pass.
    do_reset("por5");
    pass1 = 1'b1;
    tick_to(5);
    pass1 = 1'b0;
    check("pass ignored in reset", 32'(dn1), 32'd0);
    tick_to(55);
    pass1 = 1'b1;
    pass4 = 1'b1;
    trap4 = 4'b0001;
    tick_to(56);
    pass1 = 1'b0;
    pass4 = 1'b0;
    trap4 = 4'b0000;
    check("pass dn1", 32'(dn1), 32'd1);
    check("pass fl1", 32'(fl1), 32'd0);
    check("pass cc1", 32'(cc1), 32'd51);
    check("pass+trap dn4", 32'(dn4), 32'd0);
    tick_to(61);
    check("pass+trap dn4 done", 32'(dn4), 32'd1);
    check("pass+trap fl4", 32'(fl4), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
